// File: rtl/fpu_mul_result_buffer.sv
// Buffers multiplier results in a FIFO and issues operand credits so no result is ever lost.
// Latency: a result captured at edge N is visible on m_axis_* after edge N. There is no bypass path.
// Backpressure: m_axis_tready stalls the FIFO head. issue_ready withholds credit when level + inflight reaches DEPTH.
module fpu_mul_result_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              issue_fire,
  output logic              issue_ready,
  input  logic              s_axis_result_tvalid,
  input  logic [DATA_W-1:0] s_axis_result_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  inflight,
  input  logic              clear_err,
  output logic              err_overflow,
  output logic              err_credit,
  output logic              err_unexpected
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   DEPTH_SUM = (CNT_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  level_q;
  logic [CNT_W-1:0]  inflight_q;
  logic [CNT_W:0]    credit_sum;
  logic              full;
  logic              pop;
  logic              push;
  logic              accept;
  logic              retire;
  logic              overflow_evt;
  logic              credit_evt;
  logic              unexpected_evt;

  // Every control term is derived from registered state, apart from the handshake inputs that qualify it.
  assign full           = (level_q == DEPTH_CNT);
  assign m_axis_tvalid  = (level_q != '0);
  assign pop            = m_axis_tvalid & m_axis_tready;
  assign push           = s_axis_result_tvalid & (~full | pop);
  assign credit_sum     = {1'b0, level_q} + {1'b0, inflight_q};
  assign issue_ready    = (credit_sum < DEPTH_SUM);
  assign accept         = issue_fire & issue_ready;
  assign retire         = s_axis_result_tvalid & (inflight_q != '0);
  assign overflow_evt   = s_axis_result_tvalid & full & ~pop;
  assign credit_evt     = issue_fire & ~issue_ready;
  assign unexpected_evt = s_axis_result_tvalid & (inflight_q == '0);

  // The storage array needs no reset; tdata is forced to zero whenever the FIFO is empty.
  assign m_axis_tdata = m_axis_tvalid ? mem[rd_ptr] : '0;
  assign level        = level_q;
  assign inflight     = inflight_q;

  // Write the result beat into the storage array.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_result_tdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. The level tracks the net of push and pop.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Count products that have been issued but have not yet returned.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight_q <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Error flags are sticky. A new event in the same cycle takes priority over clear_err.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_overflow   <= 1'b0;
      err_credit     <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      err_overflow   <= overflow_evt   | (err_overflow   & ~clear_err);
      err_credit     <= credit_evt     | (err_credit     & ~clear_err);
      err_unexpected <= unexpected_evt | (err_unexpected & ~clear_err);
    end
  end

endmodule

// File: tb/tb_fpu_mul_result_buffer.sv
// Testbench for fpu_mul_result_buffer: directed table, corner sequences, and random traffic.
// Each cycle, the DUT outputs are compared against a queue-based reference model.
// The random traffic includes a 3-stage multiplier pipeline model with a randomly varied consumer tready.
module tb_fpu_mul_result_buffer;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          issue_fire = 1'b0;
  logic          issue_ready;
  logic          s_axis_result_tvalid = 1'b0;
  logic [DW-1:0] s_axis_result_tdata = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [CW-1:0] level;
  logic [CW-1:0] inflight;
  logic          clear_err = 1'b0;
  logic          err_overflow;
  logic          err_credit;
  logic          err_unexpected;

  fpu_mul_result_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .issue_fire(issue_fire), .issue_ready(issue_ready),
    .s_axis_result_tvalid(s_axis_result_tvalid), .s_axis_result_tdata(s_axis_result_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .level(level), .inflight(inflight), .clear_err(clear_err),
    .err_overflow(err_overflow), .err_credit(err_credit), .err_unexpected(err_unexpected)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  int            m_infl = 0;
  bit            m_eo = 0, m_ec = 0, m_eu = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic set_in(bit iss, bit rv, logic [DW-1:0] d, bit rdy, bit clr);
    issue_fire           = iss;
    s_axis_result_tvalid = rv;
    s_axis_result_tdata  = d;
    m_axis_tready        = rdy;
    clear_err            = clr;
  endtask

  task automatic cmp_model();
    chk("level", 32'(level), 32'(mq.size()));
    chk("inflight", 32'(inflight), 32'(m_infl));
    chk("tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("tdata", m_axis_tdata, mq[0]);
    chk("issue_ready", 32'(issue_ready), 32'((mq.size() + m_infl) < DEPTH));
    chk("err_overflow", 32'(err_overflow), 32'(m_eo));
    chk("err_credit", 32'(err_credit), 32'(m_ec));
    chk("err_unexpected", 32'(err_unexpected), 32'(m_eu));
  endtask

  // Advance one clock edge using the inputs currently driven, then compare against the model.
  task automatic tick();
    int sz;
    bit rdy, full, pop, push, acc, ret, ev_o, ev_c, ev_u;
    sz   = mq.size();
    rdy  = (sz + m_infl) < DEPTH;
    chk("issue_ready_pre", 32'(issue_ready), 32'(rdy));
    full = (sz == DEPTH);
    pop  = (sz > 0) && m_axis_tready;
    push = s_axis_result_tvalid && (!full || pop);
    acc  = issue_fire && rdy;
    ret  = s_axis_result_tvalid && (m_infl > 0);
    ev_o = s_axis_result_tvalid && full && !pop;
    ev_c = issue_fire && !rdy;
    ev_u = s_axis_result_tvalid && (m_infl == 0);
    @(posedge aclk);
    #1;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(s_axis_result_tdata);
    m_infl = m_infl + int'(acc) - int'(ret);
    m_eo = ev_o || (m_eo && !clear_err);
    m_ec = ev_c || (m_ec && !clear_err);
    m_eu = ev_u || (m_eu && !clear_err);
    cmp_model();
  endtask

  // Assert reset asynchronously away from a clock edge and check that it takes effect immediately.
  task automatic do_reset();
    set_in(0, 0, '0, 0, 0);
    aresetn = 1'b0;
    #2;
    mq.delete();
    m_infl = 0; m_eo = 0; m_ec = 0; m_eu = 0;
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_errs", {29'd0, err_overflow, err_credit, err_unexpected}, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    chk("rst_issue_ready", 32'(issue_ready), 1);
  endtask

  typedef struct {
    bit            iss;
    bit            rv;
    logic [DW-1:0] d;
    bit            rdy;
    bit            clr;
    int            e_lvl;
    int            e_infl;
    bit            e_tv;
    logic [DW-1:0] e_td;
    bit            e_eu;
  } vec_t;

  vec_t tbl[10];

  logic          pv[3];
  logic [DW-1:0] pd[3];

  initial begin
    // Directed table: single product, unexpected results, and clear_err priority.
    tbl[0] = '{1, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,        0};
    tbl[1] = '{0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,        0};
    tbl[2] = '{0, 0, 32'h0,        0, 0, 0, 1, 0, 32'h0,        0};
    tbl[3] = '{0, 1, 32'h40490FDB, 0, 0, 1, 0, 1, 32'h40490FDB, 0};
    tbl[4] = '{0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        0};
    tbl[5] = '{0, 1, 32'h11111111, 0, 0, 1, 0, 1, 32'h11111111, 1};
    tbl[6] = '{0, 0, 32'h0,        0, 1, 1, 0, 1, 32'h11111111, 0};
    tbl[7] = '{0, 1, 32'h22222222, 0, 1, 2, 0, 1, 32'h11111111, 1};
    tbl[8] = '{1, 0, 32'h0,        1, 0, 1, 1, 1, 32'h22222222, 1};
    tbl[9] = '{0, 1, 32'h33333333, 0, 1, 2, 0, 1, 32'h22222222, 0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].iss, tbl[i].rv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      tick();
      chk("tbl_level", 32'(level), 32'(tbl[i].e_lvl));
      chk("tbl_inflight", 32'(inflight), 32'(tbl[i].e_infl));
      chk("tbl_tvalid", 32'(m_axis_tvalid), 32'(tbl[i].e_tv));
      if (tbl[i].e_tv) chk("tbl_tdata", m_axis_tdata, tbl[i].e_td);
      chk("tbl_err_unexp", 32'(err_unexpected), 32'(tbl[i].e_eu));
    end

    // Credit fill: eight issues exhaust all credits, and the returning results fill the FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1, 0, '0, 0, 0);
      tick();
    end
    chk("t3_ready_low", 32'(issue_ready), 0);
    chk("t3_inflight8", 32'(inflight), 8);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1, 32'h3F800000 + 32'(i), 0, 0);
      tick();
    end
    chk("t3_level8", 32'(level), 8);
    chk("t3_inflight0", 32'(inflight), 0);
    chk("t3_ready_full", 32'(issue_ready), 0);
    set_in(1, 0, '0, 0, 0);
    tick();
    chk("t3_err_credit", 32'(err_credit), 1);
    chk("t3_inflight_stay", 32'(inflight), 0);

    // When the FIFO is full, a simultaneous pop and push keep the level unchanged. A push without a pop is dropped.
    set_in(0, 1, 32'hAAAA0001, 1, 0);
    tick();
    chk("t4_level_same", 32'(level), 8);
    chk("t4_no_ovf", 32'(err_overflow), 0);
    chk("t4_head", m_axis_tdata, 32'h3F800001);
    set_in(0, 1, 32'hAAAA0002, 0, 0);
    tick();
    chk("t4_ovf", 32'(err_overflow), 1);
    chk("t4_level_full", 32'(level), 8);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, '0, 1, 0);
      tick();
    end
    chk("t4_order", m_axis_tdata, 32'h3F800005);

    // Assert an asynchronous reset while traffic is still in progress.
    set_in(1, 1, 32'h5, 1, 0);
    #2;
    do_reset();

    // Wrap test: legal traffic through a 3-stage multiplier model. tready toggles first, then varies randomly.
    for (int i = 0; i < 3; i++) begin
      pv[i] = 0;
      pd[i] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit iss, rdy;
      rdy = (mq.size() + m_infl) < DEPTH;
      iss = (cyc < 380) && rdy && ($urandom_range(0, 3) != 0);
      set_in(iss, pv[2], pd[2], (cyc < 60) ? bit'(cyc % 2) : bit'($urandom_range(0, 2) == 0), 0);
      tick();
      chk("t5_invariant", 32'(32'(level) + 32'(inflight) <= DEPTH), 1);
      pv[2] = pv[1]; pd[2] = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = iss;   pd[0] = $urandom;
    end
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, '0, 1, 0);
      tick();
    end
    chk("t5_drained", 32'(level), 0);
    chk("t5_no_ovf", 32'(err_overflow), 0);
    chk("t5_no_credit_err", 32'(err_credit), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
